// File: rtl/idct_8x8_serial.sv
// idct_8x8_serial: serial 8x8 inverse DCT, one multiply-accumulate term per cycle.
// Ports: clk/rst (async active-high) | in_valid/in_ready/in_coef: raster-order signed
// coefficient stream | out_valid/out_ready/out_pixel/out_last: raster-order 8-bit
// pixel stream, out_last marks pixel 63.
module idct_8x8_serial #(
  parameter int COEF_W      = 12,
  parameter int LEVEL_SHIFT = 128,
  parameter int ACC_W       = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_pixel,
  output logic                     out_last
);
  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << 17);
  state_t state_q, state_d;
  logic [5:0] ld_q, ld_d, t_q, t_d, pix_q, pix_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, term, acc_sum, lvl;
  logic [7:0] px_q, px_d, px_sat;
  logic signed [COEF_W-1:0] mem_q [64];
  logic [4:0] fa, fb;
  logic [3:0] lo, hi;
  logic [8:0] mag;
  logic signed [9:0] b, w;
  // cos((2n+1)k*pi/16) folded onto {sign, j} with the magnitude equal to cos(j*pi/16), j in 0..8
  function automatic logic [4:0] fold(input logic [2:0] n, input logic [2:0] k);
    logic [4:0] m, j;
    m = {1'b0, n, 1'b1} * {2'b0, k};
    j = m <= 5'd8 ? m : m <= 5'd16 ? 5'd16 - m : m <= 5'd24 ? m - 5'd16 : 5'd0 - m;
    return {(m > 5'd8) && (m < 5'd25), j[3:0]};
  endfunction
  // trunc(256*cos(lo*pi/16)*cos(hi*pi/16)) for lo<=hi; truncation is sign-symmetric so signs apply afterwards
  function automatic logic [8:0] tab(input logic [3:0] l, input logic [3:0] h);
    if (h[3]) return 9'd0;
    case ({l[2:0], h[2:0]})
      6'o00: return 9'd256; 6'o01: return 9'd251; 6'o02: return 9'd236; 6'o03: return 9'd212;
      6'o04: return 9'd181; 6'o05: return 9'd142; 6'o06: return 9'd97;  6'o07: return 9'd49;
      6'o11: return 9'd246; 6'o12: return 9'd231; 6'o13: return 9'd208; 6'o14: return 9'd177;
      6'o15: return 9'd139; 6'o16: return 9'd96;  6'o17: return 9'd48;
      6'o22: return 9'd218; 6'o23: return 9'd196; 6'o24: return 9'd167; 6'o25: return 9'd131;
      6'o26: return 9'd90;  6'o27: return 9'd46;
      6'o33: return 9'd176; 6'o34: return 9'd150; 6'o35: return 9'd118; 6'o36: return 9'd81;
      6'o37: return 9'd41;
      6'o44: return 9'd128; 6'o45: return 9'd100; 6'o46: return 9'd69;  6'o47: return 9'd35;
      6'o55: return 9'd79;  6'o56: return 9'd54;  6'o57: return 9'd27;
      6'o66: return 9'd37;  6'o67: return 9'd19;
      6'o77: return 9'd9;
      default: return 9'd0;
    endcase
  endfunction
  always_comb begin
    fa = fold(pix_q[5:3], t_q[5:3]);
    fb = fold(pix_q[2:0], t_q[2:0]);
    lo = fa[3:0] < fb[3:0] ? fa[3:0] : fb[3:0];
    hi = fa[3:0] < fb[3:0] ? fb[3:0] : fa[3:0];
    mag = tab(lo, hi);
    b = (fa[4] ^ fb[4]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    w = (t_q[5:3] == 3'd0 && t_q[2:0] == 3'd0) ? 10'sd128 :
        (t_q[5:3] == 3'd0 || t_q[2:0] == 3'd0) ? 10'sd181 : 10'sd256;
    term = ACC_W'(mem_q[t_q]) * ACC_W'(b) * ACC_W'(w);
    acc_sum = acc_q + term;
    lvl = ((acc_sum + HALF) >>> 18) + ACC_W'(LEVEL_SHIFT);
    px_sat = lvl < 0 ? 8'd0 : lvl > 255 ? 8'd255 : lvl[7:0];
  end
  always_comb begin
    state_d = state_q;
    ld_d = ld_q;
    t_d = t_q;
    pix_d = pix_q;
    acc_d = acc_q;
    px_d = px_q;
    case (state_q)
      LOAD: if (in_valid) begin
        ld_d = ld_q + 6'd1;
        if (ld_q == 6'd63) begin
          state_d = COMPUTE;
          t_d = '0;
          acc_d = '0;
        end
      end
      COMPUTE: begin
        acc_d = acc_sum;
        t_d = t_q + 6'd1;
        if (t_q == 6'd63) begin
          state_d = OUTPUT;
          px_d = px_sat;
        end
      end
      OUTPUT: if (out_ready) begin
        state_d = pix_q == 6'd63 ? LOAD : COMPUTE;
        pix_d = pix_q + 6'd1;
        acc_d = '0;
        t_d = '0;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      ld_q <= '0;
      t_q <= '0;
      pix_q <= '0;
      acc_q <= '0;
      px_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q <= ld_d;
      t_q <= t_d;
      pix_q <= pix_d;
      acc_q <= acc_d;
      px_q <= px_d;
    end
  always_ff @(posedge clk)
    if (state_q == LOAD && in_valid) mem_q[ld_q] <= in_coef;
  assign in_ready = state_q == LOAD;
  assign out_valid = state_q == OUTPUT;
  assign out_last = out_valid && pix_q == 6'd63;
  assign out_pixel = px_q;
endmodule

// File: tb/tb_idct_8x8_serial.sv
// tb_idct_8x8_serial: self-checking bench for idct_8x8_serial against a real-valued cosine model.
module tb_idct_8x8_serial;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic signed [11:0] in_coef = '0;
  logic [7:0] out_pixel;
  int n_cmp = 0, n_fail = 0;
  int blk[64], expv[64], got[64];
  typedef struct {
    string name;
    int dc;
    int ac_idx;
    int ac_val;
    int p0;
    int p1;
  } vec_t;
  vec_t vecs[5];
  always #5 clk = ~clk;
  idct_8x8_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_last(out_last)
  );
  function automatic int basis(int n1, int n2, int k1, int k2);
    real x;
    x = 256.0 * $cos((2 * n1 + 1) * k1 * PI / 16.0) * $cos((2 * n2 + 1) * k2 * PI / 16.0);
    x = x + ((x >= 0.0) ? 1e-6 : -1e-6);
    return $rtoi(x);
  endfunction
  function automatic int weight(int k1, int k2);
    return (k1 == 0 && k2 == 0) ? 128 : (k1 == 0 || k2 == 0) ? 181 : 256;
  endfunction
  function automatic void build_model();
    longint acc, r;
    for (int p = 0; p < 64; p++) begin
      acc = 0;
      for (int t = 0; t < 64; t++)
        acc += longint'(blk[t]) * basis(p / 8, p % 8, t / 8, t % 8) * weight(t / 8, t % 8);
      r = ((acc + 131072) >>> 18) + 128;
      expv[p] = r < 0 ? 0 : r > 255 ? 255 : int'(r);
    end
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask
  task automatic load_block(input bit gaps);
    int i, cyc;
    bit fire;
    i = 0;
    cyc = 0;
    while (i < 64 && cyc < 1000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_coef = in_valid ? 12'(blk[i]) : 12'($urandom);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (fire) i++;
    end
    chk("load_count", i, 64);
    chk("in_ready_after_load", int'(in_ready), 0);
    in_valid = 1'b0;
  endtask
  task automatic collect(input int npix, input bit stall);
    int cyc;
    logic [7:0] px;
    logic lst;
    for (int p = 0; p < npix; p++) begin
      cyc = 0;
      while (!out_valid && cyc < 200) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("latency", cyc, 64);
      in_valid = 1'b0;
      got[p] = int'(out_pixel);
      chk($sformatf("pixel[%0d]", p), int'(out_pixel), expv[p]);
      chk($sformatf("last[%0d]", p), int'(out_last), int'(p == 63));
      px = out_pixel;
      lst = out_last;
      if (stall && (p == 0 || p == 31 || p == 63))
        repeat (10) begin
          @(posedge clk);
          #1;
          chk("stall_pixel", int'(out_pixel), int'(px));
          chk("stall_last", int'(out_last), int'(lst));
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_in_ready", int'(in_ready), 0);
        end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("valid_after_hs", int'(out_valid), 0);
      chk("in_ready_after_hs", int'(in_ready), int'(p == 63));
    end
  endtask
  initial begin
    #950000;
    $display("FAIL watchdog: run still active at time limit, required completion");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{"zero", 0, 1, 0, 128, 128};
    vecs[1] = '{"dc512", 512, 1, 0, 192, 192};
    vecs[2] = '{"dc_min", -2048, 1, 0, 0, 0};
    vecs[3] = '{"dc_max", 2047, 1, 0, 255, 255};
    vecs[4] = '{"ac45", 0, 37, 256, 153, 84};
    #23;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 64; i++) blk[i] = 0;
      blk[0] = vecs[v].dc;
      blk[vecs[v].ac_idx] = vecs[v].ac_val;
      build_model();
      load_block(1'b0);
      collect(64, 1'b0);
      chk({vecs[v].name, "_p0"}, got[0], vecs[v].p0);
      chk({vecs[v].name, "_p1"}, got[1], vecs[v].p1);
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++)
        blk[i] = (r == 0) ? int'($urandom_range(0, 4095)) - 2048 :
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 400)) - 200;
      if (r != 0) blk[0] = int'($urandom_range(0, 1200)) - 600;
      build_model();
      load_block(1'b0);
      collect(64, r == 2);
    end
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 300)) - 150;
    build_model();
    load_block(1'b1);
    in_valid = 1'b1;
    in_coef = 12'sh7ff;
    collect(64, 1'b0);
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 200)) - 100;
    build_model();
    load_block(1'b0);
    collect(5, 1'b0);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_pixel", int'(out_pixel), 0);
    chk("midrst_out_last", int'(out_last), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = 512;
    build_model();
    load_block(1'b0);
    collect(64, 1'b0);
    chk("post_rst_p10", got[10], 192);
    chk("post_rst_p63", got[63], 192);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
